// File: rtl/xpu_vpu_pc_tn_vlsu_pkg.sv
// Shared definitions for the vector LSU indexed-access path:
// index-width default, pointer sizing and the default-geometry entry payload.
package xpu_vpu_pc_tn_vlsu_pkg;

    localparam int unsigned IDX_WIDTH_DFLT = 64;
    localparam int unsigned LANES_DFLT     = 2;

    // Payload of one index/vmask queue entry at the default geometry
    typedef struct packed {
        logic [LANES_DFLT-1:0][IDX_WIDTH_DFLT-1:0] offset;
        logic [LANES_DFLT-1:0]                     vmask;
    } icq_payload_t;

    // Circular-queue pointer width: index bits plus one wrap bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_index_vm_qentry.sv
// One index/vmask queue entry: valid bit with set/clear/flush, plus a
// payload captured only on set (payload flops carry no reset).
module xpu_vpu_pc_tn_vlsu_index_vm_qentry
    import xpu_vpu_pc_tn_vlsu_pkg::*;
#(
    parameter int unsigned LANES     = LANES_DFLT,
    parameter int unsigned IDX_WIDTH = IDX_WIDTH_DFLT
) (
    input  logic                         vv_icq_clk,
    input  logic                         cpurst,
    input  logic                         ent_set,
    input  logic                         ent_clr,
    input  logic                         ent_flush,
    input  logic [LANES*IDX_WIDTH-1:0]   ent_set_idx_offset,
    input  logic [LANES-1:0]             ent_set_vmask,
    output logic                         ent_vld,
    output logic [LANES*IDX_WIDTH-1:0]   ent_idx_offset,
    output logic [LANES-1:0]             ent_vmask
);

    // Flush dominates; set and clear never target the same entry together
    always_ff @(posedge vv_icq_clk or posedge cpurst) begin
        if (cpurst) begin
            ent_vld <= 1'b0;
        end else if (ent_flush) begin
            ent_vld <= 1'b0;
        end else if (ent_set) begin
            ent_vld <= 1'b1;
        end else if (ent_clr) begin
            ent_vld <= 1'b0;
        end
    end

    always_ff @(posedge vv_icq_clk) begin
        if (ent_set) begin
            ent_idx_offset <= ent_set_idx_offset;
            ent_vmask      <= ent_set_vmask;
        end
    end

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_index_vm_queue.sv
// In-order index/vmask queue feeding address generation; optionally drops
// fully-masked uops at the head without presenting them.
module xpu_vpu_pc_tn_vlsu_index_vm_queue
    import xpu_vpu_pc_tn_vlsu_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned LANES       = 2,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DFLT,
    parameter int unsigned AFULL_LVL   = 6,
    parameter int unsigned SKIP_MASKED = 1
) (
    input  logic                         vv_icq_clk,
    input  logic                         cpurst,
    input  logic                         giu_xx_async_flush,
    input  logic                         vv_icq_crt_vld,
    output logic                         vv_icq_crt_rdy,
    input  logic [LANES*IDX_WIDTH-1:0]   vv_icq_crt_idx_offset,
    input  logic [LANES-1:0]             vv_icq_crt_vmask,
    output logic                         vv_icq_head_vld,
    input  logic                         vv_icq_head_rdy,
    output logic [LANES*IDX_WIDTH-1:0]   vv_icq_head_idx_offset,
    output logic [LANES-1:0]             vv_icq_head_vmask,
    output logic [$clog2(DEPTH):0]       vv_icq_cnt,
    output logic                         vv_icq_empty,
    output logic                         vv_icq_full,
    output logic                         vv_icq_afull
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned AW    = PTR_W - 1;
    localparam int unsigned OFF_W = LANES * IDX_WIDTH;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    logic [DEPTH-1:0] ent_vld;
    logic [OFF_W-1:0] ent_idx_offset [DEPTH];
    logic [LANES-1:0] ent_vmask      [DEPTH];

    logic push;
    logic pop;
    logic head_ent_vld;
    logic head_masked;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Status is derived from registered pointers only
    assign vv_icq_empty = (wr_ptr == rd_ptr);
    assign vv_icq_full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign vv_icq_cnt   = wr_ptr - rd_ptr;
    assign vv_icq_afull = (vv_icq_cnt >= PTR_W'(AFULL_LVL));

    assign vv_icq_crt_rdy = ~vv_icq_full;
    assign push           = vv_icq_crt_vld & vv_icq_crt_rdy;

    // Head payload mux, forced to zero when the head slot holds nothing
    assign head_ent_vld           = ent_vld[rd_idx];
    assign vv_icq_head_idx_offset = head_ent_vld ? ent_idx_offset[rd_idx] : '0;
    assign vv_icq_head_vmask      = head_ent_vld ? ent_vmask[rd_idx] : '0;

    assign head_masked     = (SKIP_MASKED != 0) && (ent_vmask[rd_idx] == '0);
    assign vv_icq_head_vld = ~vv_icq_empty & ~head_masked;
    assign pop             = (vv_icq_head_vld & vv_icq_head_rdy)
                           | (~vv_icq_empty & head_masked);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        xpu_vpu_pc_tn_vlsu_index_vm_qentry #(
            .LANES     (LANES),
            .IDX_WIDTH (IDX_WIDTH)
        ) u_qentry (
            .vv_icq_clk         (vv_icq_clk),
            .cpurst             (cpurst),
            .ent_set            (push & (wr_idx == AW'(i))),
            .ent_clr            (pop & (rd_idx == AW'(i))),
            .ent_flush          (giu_xx_async_flush),
            .ent_set_idx_offset (vv_icq_crt_idx_offset),
            .ent_set_vmask      (vv_icq_crt_vmask),
            .ent_vld            (ent_vld[i]),
            .ent_idx_offset     (ent_idx_offset[i]),
            .ent_vmask          (ent_vmask[i])
        );
    end

    // Flush overrides any same-cycle push or pop
    always_ff @(posedge vv_icq_clk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (giu_xx_async_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/xpu_vpu_pc_tn_vlsu_index_vm_queue.md
# xpu_vpu_pc_tn_vlsu_index_vm_queue

Parametrised index/vmask queue for the vector LSU indexed-access path. It holds up to DEPTH uops, each carrying LANES index offsets and LANES mask bits. Uops are released in order to the address-generation stage, and fully-masked uops are optionally dropped at the head without being presented. It replaces the per-entry flop arrays with a single circular queue that has occupancy, almost-full and flush support.

## Interface
- DEPTH, 8, entries; power of 2, ≥2
- LANES, 2, index offsets per entry
- IDX_WIDTH, 64, bits per index offset
- AFULL_LVL, 6, count at or above which `vv_icq_afull` asserts; 1..DEPTH
- SKIP_MASKED, 1, 1 = auto-drop head entries whose vmask is all zero
- `vv_icq_clk` in 1: single clock, all state on its rising edge
- `cpurst` in 1: reset, asynchronous, active-high
- `giu_xx_async_flush` in 1: flush, sampled synchronously
- `vv_icq_crt_vld` in 1: create request
- `vv_icq_crt_rdy` out 1: create accepted when high
- `vv_icq_crt_idx_offset` in LANES*IDX_WIDTH: lane i at [i*IDX_WIDTH +: IDX_WIDTH]
- `vv_icq_crt_vmask` in LANES: per-lane mask
- `vv_icq_head_vld` out 1: head entry presented
- `vv_icq_head_rdy` in 1: consumer takes head
- `vv_icq_head_idx_offset` out LANES*IDX_WIDTH: head offsets
- `vv_icq_head_vmask` out LANES: head mask
- `vv_icq_cnt` out $clog2(DEPTH)+1: occupancy
- `vv_icq_empty` out 1, `vv_icq_full` out 1, `vv_icq_afull` out 1

## Operation
- Storage: DEPTH entries, each with a valid bit, LANES×IDX_WIDTH offset and LANES mask bits. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
- Empty: the pointers are equal. Full: low bits are equal and wrap bits differ. cnt = wr_ptr − rd_ptr, modulo 2^(ptrw).
- `crt_rdy = ~full`, a registered-state function that never depends on `head_rdy`. Push = crt_vld & crt_rdy. A push writes the entry at wr_ptr, sets its valid bit and increments wr_ptr.
- Head entry = entry at rd_ptr when the queue is not empty. `head_masked` = SKIP_MASKED & (head vmask == 0).
- `head_vld` = ~empty & ~head_masked. Pop = (head_vld & head_rdy) | (~empty & head_masked). A pop clears the valid bit and increments rd_ptr. At most one pop per cycle.
- Head data outputs are driven from the entry at rd_ptr. Their value is don't-care when `head_vld` is 0, but the outputs are zero after reset.
- Push and pop in the same cycle are both honoured and cnt is unchanged. Because full blocks push, push and pop never collide on the same entry.
- Flush has priority over push and pop. In a flush cycle all valid bits are cleared, both pointers go to 0, and any push or pop in that cycle is discarded. crt_rdy is still driven from pre-flush state.
- Entry payload is written only on push, with no reset on payload flops.

## Timing
- Reset (cpurst high, asynchronous): pointers 0, all valid bits 0. Outputs: cnt=0, empty=1, full=0, afull=0, crt_rdy=1, head_vld=0.
- Head offset/vmask outputs are 0 at reset because the payload output mux is gated by valid.
- Reset asserted mid-operation discards all contents immediately, independent of the clock.
- Push-to-head latency is 1 cycle: an entry pushed in cycle N is visible at head in N+1 if the queue was empty.
- A masked head is dropped 1 cycle after it becomes head. A run of k masked entries costs k cycles with head_vld=0.
- `head_vld` may deassert only via pop or flush. Once high without flush, it stays high with stable data until head_rdy.
- full, empty, cnt and afull reflect post-edge state. They are registered-pointer derived, with no combinational path from crt_vld or head_rdy.

## Structure
- Shared package `xpu_vpu_pc_tn_vlsu_pkg`: IDX_WIDTH default (replaces the global index-width macro), pointer-width function, and the entry payload struct (offset array plus vmask).
- Sub-module `xpu_vpu_pc_tn_vlsu_index_vm_qentry` (LANES, IDX_WIDTH) holds the valid bit plus payload, with set/clear/flush inputs. It is instantiated DEPTH times; the top holds the pointers, count and head mux.

## Test plan
- Reset, then push 8 entries with offsets 0x10..0x17 and vmask 2'b11, no head_rdy → full=1, crt_rdy=0, cnt=8, afull=1 from cnt=6. Then head_rdy=1 for 8 cycles → offsets popped in order 0x10..0x17, empty=1.
- Steady push+pop each cycle for 20 cycles with pointer wrap → cnt stays 1, no loss or reorder, wrap bit toggles every 8 pops.
- SKIP_MASKED=1: push vmask 2'b01, 2'b00, 2'b00, 2'b10 with head_rdy=1 → head_vld pulses for entries 0 and 3 only, cnt reaches 0 in 4 cycles.
- SKIP_MASKED=0 with the same stimulus → all 4 entries presented, 2'b00 ones included.
- Flush with cnt=5 while crt_vld=1 and head_rdy=1 → next cycle cnt=0, empty=1, head_vld=0, the pushed uop is not stored.
- Assert cpurst asynchronously mid-stream with cnt=3 → outputs reach reset values before the next clock edge, and a push after release appears at head 1 cycle later.
